// File: rtl/slv_wrp_if.sv
// slv_wrp_if: Core-B Lite bus-side signals seen by one slave wrapper.
// The master modport is the bus/decoder side, the slave modport is slv_wrp.
interface slv_wrp_if;
  logic        SxSEL;
  logic        MsRDY;
  logic        MxWT;
  logic [2:0]  MxSZ;
  logic [3:0]  MxRB;
  logic [2:0]  MxMOD;
  logic [31:0] MxADDR;
  logic [38:0] MxWDT;
  logic        SxRDY;
  logic        SxERR;
  logic [38:0] SxRDT;

  modport master (
    output SxSEL, MsRDY, MxWT, MxSZ, MxRB, MxMOD, MxADDR, MxWDT,
    input  SxRDY, SxERR, SxRDT
  );

  modport slave (
    input  SxSEL, MsRDY, MxWT, MxSZ, MxRB, MxMOD, MxADDR, MxWDT,
    output SxRDY, SxERR, SxRDT
  );
endinterface

// File: rtl/slv_wrp.sv
// slv_wrp: Core-B Lite slave wrapper. Captures selected address phases and
// turns each data phase into one single-beat request to a simple slave core.
// Optional data-phase timeout: define SLV_WRP_TIMEOUT_EN (limit = TO_CYCLES).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no data phase owned; SxRDY=1, ready to accept
// ST_DATA | core request outstanding; completes on SCx_ACK
// ST_ERR1 | first error cycle (SxRDY=0, SxERR=1), no core request
// ST_ERR2 | second error cycle (SxRDY=1, SxERR=1), may accept next phase
module slv_wrp #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  slv_wrp_if.slave    bus,
  output logic        SCx_REQ,
  output logic        SCx_WT,
  output logic [2:0]  SCx_SZ,
  output logic [31:0] SCx_ADDR,
  output logic [38:0] SCx_WDT,
  input  logic        SCx_ACK,
  input  logic        SCx_ERR,
  input  logic [38:0] SCx_RDT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_ok;
  logic        bad;
  logic        can_acc;
  logic        acc;
  logic        to_hit;
  logic        rd_done;
  logic        rdy;
  logic        err;
  logic        req;
  logic        wt_q;
  logic [2:0]  sz_q;
  logic [31:0] addr_q;
  logic [3:0]  rb_q;
  logic [38:0] rdt_q;

  assign sel_ok = bus.SxSEL & (bus.MxMOD != 3'd0) & bus.MsRDY;

  // Illegal size or an address not aligned to the transfer size.
  assign bad = (bus.MxSZ > 3'd2)
             | ((bus.MxSZ == 3'd1) & bus.MxADDR[0])
             | ((bus.MxSZ == 3'd2) & (bus.MxADDR[1:0] != 2'b00));

  // Only states that are finishing (or have no) data phase may take a new
  // address phase, so a stray MsRDY during ST_ERR1 cannot disturb the latches.
  always_comb begin
    can_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: can_acc = 1'b1;
      ST_DATA: can_acc = SCx_ACK;
      ST_ERR1: can_acc = 1'b0;
      ST_ERR2: can_acc = 1'b1;
      default: can_acc = 1'b0;
    endcase
  end

  assign acc = sel_ok & can_acc;

`ifdef SLV_WRP_TIMEOUT_EN
  // Abort fires on the last allowed wait cycle, giving exactly TO_CYCLES
  // data-phase cycles before the error response starts.
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  logic [7:0] to_cnt;

  assign to_hit = (state_q == ST_DATA) & ~SCx_ACK & (to_cnt == TO_LAST);

  // Wait-cycle counter: cleared by each accepted address phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt <= 8'd0;
    end else if (acc) begin
      to_cnt <= 8'd0;
    end else if ((state_q == ST_DATA) && !SCx_ACK) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus/core handshake outputs.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b1;
    err     = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) state_d = bad ? ST_ERR1 : ST_DATA;
      end
      ST_DATA: begin
        req = 1'b1;
        rdy = SCx_ACK;
        err = SCx_ACK & SCx_ERR;
        if (to_hit) begin
          state_d = ST_ERR1;
        end else if (SCx_ACK) begin
          if (acc) state_d = bad ? ST_ERR1 : ST_DATA;
          else     state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        rdy     = 1'b0;
        err     = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        rdy = 1'b1;
        err = 1'b1;
        if (acc) state_d = bad ? ST_ERR1 : ST_DATA;
        else     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-phase capture; held until the next accepted phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wt_q   <= 1'b0;
      sz_q   <= 3'd0;
      addr_q <= 32'd0;
      rb_q   <= 4'd0;
    end else if (acc) begin
      wt_q   <= bus.MxWT;
      sz_q   <= bus.MxSZ;
      addr_q <= bus.MxADDR;
      rb_q   <= bus.MxRB;
    end
  end

  assign rd_done = (state_q == ST_DATA) & SCx_ACK & ~wt_q;

  // Read-data hold so SxRDT stays at the last completed read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdt_q <= 39'd0;
    end else if (rd_done) begin
      rdt_q <= SCx_RDT;
    end
  end

  assign bus.SxRDY = rdy;
  assign bus.SxERR = err;
  assign bus.SxRDT = rd_done ? SCx_RDT : rdt_q;

  assign SCx_REQ  = req;
  assign SCx_WT   = wt_q;
  assign SCx_SZ   = sz_q;
  assign SCx_ADDR = addr_q;
  assign SCx_WDT  = bus.MxWDT;

endmodule

// File: tb/tb_slv_wrp.sv
// tb_slv_wrp: directed vectors for slv_wrp with hand-computed expectations.
// Single-slave bus: MsRDY is this slave's own SxRDY.
module tb_slv_wrp;

`ifdef SLV_WRP_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        CLK;
  logic        nRST;
  logic        SCx_REQ;
  logic        SCx_WT;
  logic [2:0]  SCx_SZ;
  logic [31:0] SCx_ADDR;
  logic [38:0] SCx_WDT;
  logic        SCx_ACK;
  logic        SCx_ERR;
  logic [38:0] SCx_RDT;

  int n_cmp;
  int n_err;

  slv_wrp_if bus ();

  assign bus.MsRDY = bus.SxRDY;

  slv_wrp #(.TO_CYCLES(TO)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .SCx_REQ  (SCx_REQ),
    .SCx_WT   (SCx_WT),
    .SCx_SZ   (SCx_SZ),
    .SCx_ADDR (SCx_ADDR),
    .SCx_WDT  (SCx_WDT),
    .SCx_ACK  (SCx_ACK),
    .SCx_ERR  (SCx_ERR),
    .SCx_RDT  (SCx_RDT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_val(input string tag, input logic [38:0] act, input logic [38:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input logic sel, input logic [2:0] mode, input logic wt,
                          input logic [2:0] sz, input logic [31:0] addr);
    bus.SxSEL  = sel;
    bus.MxMOD  = mode;
    bus.MxWT   = wt;
    bus.MxSZ   = sz;
    bus.MxADDR = addr;
    bus.MxRB   = 4'd0;
  endtask

  task automatic chk_rsp(input string tag, input logic rdy, input logic err, input logic req);
    chk_val({tag, "_rdy"}, 39'(bus.SxRDY), 39'(rdy));
    chk_val({tag, "_err"}, 39'(bus.SxERR), 39'(err));
    chk_val({tag, "_req"}, 39'(SCx_REQ), 39'(req));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    nRST    = 1'b0;
    SCx_ACK = 1'b0;
    SCx_ERR = 1'b0;
    SCx_RDT = 39'd0;
    bus.MxWDT = 39'd0;
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);

    // reset values
    #12;
    chk_rsp("rst", 1'b1, 1'b0, 1'b0);
    chk_val("rst_rdt", bus.SxRDT, 39'd0);
    chk_val("rst_addr", 39'(SCx_ADDR), 39'd0);
    chk_val("rst_wt", 39'(SCx_WT), 39'd0);
    chk_val("rst_sz", 39'(SCx_SZ), 39'd0);
    tick();
    nRST = 1'b1;
    tick();

    // non-transfer: selected but MxMOD=0, then MxMOD!=0 but not selected
    set_addr(1'b1, 3'd0, 1'b1, 3'd2, 32'h44);
    tick();
    set_addr(1'b0, 3'd1, 1'b1, 3'd2, 32'h48);
    #1;
    chk_rsp("nontr1", 1'b1, 1'b0, 1'b0);
    chk_val("nontr1_addr", 39'(SCx_ADDR), 39'd0);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    #1;
    chk_rsp("nontr2", 1'b1, 1'b0, 1'b0);
    chk_val("nontr2_addr", 39'(SCx_ADDR), 39'd0);

    // zero-wait word write
    set_addr(1'b1, 3'd1, 1'b1, 3'd2, 32'h10);
    SCx_ACK = 1'b1;
    #1;
    chk_rsp("wr_ap", 1'b1, 1'b0, 1'b0);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    bus.MxWDT = 39'h0A5A5A5A5;
    #1;
    chk_rsp("wr_dp", 1'b1, 1'b0, 1'b1);
    chk_val("wr_addr", 39'(SCx_ADDR), 39'h10);
    chk_val("wr_wt", 39'(SCx_WT), 39'd1);
    chk_val("wr_sz", 39'(SCx_SZ), 39'd2);
    chk_val("wr_wdt", SCx_WDT, 39'h0A5A5A5A5);
    tick();
    SCx_ACK = 1'b0;
    #1;
    chk_rsp("wr_idle", 1'b1, 1'b0, 1'b0);

    // wait-state read: three wait cycles then ACK
    set_addr(1'b1, 3'd1, 1'b0, 3'd2, 32'h20);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rsp($sformatf("rd_wait%0d", i), 1'b0, 1'b0, 1'b1);
      chk_val($sformatf("rd_addr%0d", i), 39'(SCx_ADDR), 39'h20);
      tick();
    end
    SCx_ACK = 1'b1;
    SCx_RDT = 39'h12345678;
    #1;
    chk_rsp("rd_ack", 1'b1, 1'b0, 1'b1);
    chk_val("rd_rdt", bus.SxRDT, 39'h12345678);
    tick();
    SCx_ACK = 1'b0;
    SCx_RDT = 39'h7F_FFFF_FFFF;
    #1;
    chk_rsp("rd_idle", 1'b1, 1'b0, 1'b0);
    chk_val("rd_hold", bus.SxRDT, 39'h12345678);

    // misaligned word, odd halfword, illegal size: two-cycle error each
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_addr(1'b1, 3'd1, 1'b0, 3'd2, 32'h22);
        1: set_addr(1'b1, 3'd2, 1'b1, 3'd1, 32'h31);
        default: set_addr(1'b1, 3'd1, 1'b0, 3'd3, 32'h40);
      endcase
      tick();
      set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
      SCx_ACK = 1'b1;
      #1;
      chk_rsp($sformatf("bad%0d_e1", k), 1'b0, 1'b1, 1'b0);
      tick();
      #1;
      chk_rsp($sformatf("bad%0d_e2", k), 1'b1, 1'b1, 1'b0);
      tick();
      SCx_ACK = 1'b0;
      #1;
      chk_rsp($sformatf("bad%0d_idle", k), 1'b1, 1'b0, 1'b0);
    end
    chk_val("bad_rdt_kept", bus.SxRDT, 39'h12345678);

    // halfword at even address is legal, core returns error
    set_addr(1'b1, 3'd1, 1'b1, 3'd1, 32'h52);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    SCx_ACK = 1'b1;
    SCx_ERR = 1'b1;
    #1;
    chk_rsp("cerr", 1'b1, 1'b1, 1'b1);
    chk_val("cerr_sz", 39'(SCx_SZ), 39'd1);
    tick();
    SCx_ACK = 1'b0;
    SCx_ERR = 1'b0;

    // four pipelined zero-wait reads
    set_addr(1'b1, 3'd1, 1'b0, 3'd2, 32'h0);
    SCx_ACK = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) set_addr(1'b1, 3'd1, 1'b0, 3'd2, 32'(4 * k));
      else       set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
      SCx_RDT = 39'(32'h100 + k);
      #1;
      chk_rsp($sformatf("pipe%0d", k), 1'b1, 1'b0, 1'b1);
      chk_val($sformatf("pipe%0d_addr", k), 39'(SCx_ADDR), 39'(4 * (k - 1)));
      chk_val($sformatf("pipe%0d_rdt", k), bus.SxRDT, 39'(32'h100 + k));
      tick();
    end
    SCx_ACK = 1'b0;
    #1;
    chk_rsp("pipe_idle", 1'b1, 1'b0, 1'b0);

    // reset during a pending data phase
    set_addr(1'b1, 3'd1, 1'b1, 3'd0, 32'h33);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    #1;
    chk_rsp("abort_pend", 1'b0, 1'b0, 1'b1);
    chk_val("abort_addr", 39'(SCx_ADDR), 39'h33);
    nRST = 1'b0;
    #1;
    chk_rsp("abort_rst", 1'b1, 1'b0, 1'b0);
    chk_val("abort_addr0", 39'(SCx_ADDR), 39'd0);
    chk_val("abort_wt0", 39'(SCx_WT), 39'd0);
    chk_val("abort_rdt0", bus.SxRDT, 39'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    set_addr(1'b1, 3'd1, 1'b1, 3'd0, 32'h7);
    SCx_ACK = 1'b1;
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    #1;
    chk_rsp("after_rst", 1'b1, 1'b0, 1'b1);
    chk_val("after_rst_addr", 39'(SCx_ADDR), 39'h7);
    tick();
    SCx_ACK = 1'b0;
    #1;
    chk_rsp("after_rst_idle", 1'b1, 1'b0, 1'b0);

`ifdef SLV_WRP_TIMEOUT_EN
    // core never acks: 8 data-phase cycles, then two-cycle error
    set_addr(1'b1, 3'd1, 1'b0, 3'd2, 32'h60);
    tick();
    set_addr(1'b0, 3'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_rsp($sformatf("to_wait%0d", i), 1'b0, 1'b0, 1'b1);
      tick();
    end
    SCx_ACK = 1'b1;
    SCx_RDT = 39'h55;
    #1;
    chk_rsp("to_e1", 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    chk_rsp("to_e2", 1'b1, 1'b1, 1'b0);
    tick();
    SCx_ACK = 1'b0;
    #1;
    chk_rsp("to_idle", 1'b1, 1'b0, 1'b0);
    chk_val("to_rdt", bus.SxRDT, 39'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slv_wrp.md
# slv_wrp

Slave wrapper for the Core-B Lite on-chip high-speed bus: the responder end of the pipelined address/data-phase protocol driven by the master wrappers. It sits between the bus decoder/response mux and a simple slave core, such as the UART register file. It captures each selected address phase and issues one single-beat request per data phase to the core. It returns ready, error and read data to the bus.

## Interface
Parameters:
- TO_CYCLES, 255: data-phase timeout limit in clock cycles (used only with SLV_WRP_TIMEOUT_EN).

Ports:
- CLK  input  1  bus clock; all state on rising edge.
- nRST  input  1  reset; one clock; reset is asynchronous and active-low.
- SxSEL  input  1  decoder select for this slave, valid in the address phase.
- MsRDY  input  1  bus-wide ready (muxed ready of the current data-phase slave); an address phase is accepted only when high.
- MxWT  input  1  write(1)/read(0).
- MxSZ  input  3  transfer size: 0 byte, 1 halfword, 2 word; 3-7 illegal.
- MxRB  input  4  remaining beats; informational, captured only.
- MxMOD  input  3  transfer mode; 0 = idle, non-zero = valid transfer.
- MxADDR  input  32  address-phase address.
- MxWDT  input  39  write data, valid in the data phase.
- SxRDY  output  1  data phase complete / slave ready.
- SxERR  output  1  error response, qualified by SxRDY.
- SxRDT  output  39  read data, valid when SxRDY & read.
- SCx_REQ  output  1  core request, held until SCx_ACK.
- SCx_WT  output  1  latched write flag.
- SCx_SZ  output  3  latched size.
- SCx_ADDR  output  32  latched address.
- SCx_WDT  output  39  write data (MxWDT passed through in the data phase).
- SCx_ACK  input  1  core completes the request this cycle.
- SCx_ERR  input  1  core error, qualified by SCx_ACK.
- SCx_RDT  input  39  core read data, qualified by SCx_ACK.

## Operation
- **Address accept:** the block accepts an address phase when SxSEL & (MxMOD!=0) & MsRDY. On accept it latches MxWT, MxSZ, MxADDR and MxRB, and computes `bad`:
  - MxSZ>2, or
  - MxSZ==1 & MxADDR[0], or
  - MxSZ==2 & MxADDR[1:0]!=0.
- **FSM states:** ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2 (2-bit).
- **ST_IDLE:**
  - Outputs: SxRDY=1, SxERR=0, SCx_REQ=0.
  - Accept with !bad goes to ST_DATA; accept with bad goes to ST_ERR1.
- **ST_DATA:**
  - Outputs: SCx_REQ=1; SxRDY=SCx_ACK and SxERR=SCx_ACK&SCx_ERR, both combinational.
  - SCx_ACK=0: stay in ST_DATA.
  - SCx_ACK=1: go to ST_DATA or ST_ERR1 if a new accept occurs in the same cycle (pipelined back-to-back), otherwise to ST_IDLE.
- **Error response:** two cycles.
  - ST_ERR1: SxRDY=0, SxERR=1.
  - ST_ERR2: SxRDY=1, SxERR=1.
  - No core request is issued in either state.
  - From ST_ERR2, go to ST_DATA or ST_ERR1 on a new accept, otherwise to ST_IDLE.
- **Read data:**
  - SxRDT = SCx_RDT when ST_DATA & SCx_ACK & !SCx_WT; otherwise the held register value.
  - The hold register loads on that same condition.
- **Write data:** SCx_WDT = MxWDT (combinational); the core samples it on the ACK cycle.
- **Reset mid-transfer:** FSM returns to ST_IDLE, all latches clear, SCx_REQ drops immediately.

## Timing
- **Reset values:** SxRDY=1, SxERR=0, SxRDT=0, SCx_REQ=0, SCx_WT=0, SCx_SZ=0, SCx_ADDR=0. SCx_WDT follows MxWDT.
- **Core latency:**
  - Zero-wait core (SCx_ACK in the first data-phase cycle) completes each beat in 1 cycle; back-to-back beats sustain 1 beat/cycle.
  - N wait cycles from the core give an N+1-cycle data phase.
- **Error timing:** an error response always takes exactly 2 cycles.
- **Stability:** SCx_REQ, SCx_ADDR, SCx_WT and SCx_SZ stay stable from the cycle after accept until the ACK cycle inclusive.
- **Non-transfers:** an address phase with SxSEL=0 or MxMOD=0 is never latched; SxRDY stays 1.

## Configuration
- **SLV_WRP_TIMEOUT_EN defined:**
  - An 8-bit counter clears on entry to ST_DATA and increments each ST_DATA cycle without SCx_ACK.
  - When it reaches TO_CYCLES, SCx_REQ drops and the FSM enters ST_ERR1 (two-cycle error response).
  - A late SCx_ACK arriving after the abort is ignored.
- **Undefined:** no counter; ST_DATA waits for SCx_ACK indefinitely.

## Test plan
- **Zero-wait word write:** SxSEL=1, MxMOD=1, MxWT=1, MxSZ=2, ADDR=0x10, WDT=0x0A5A5A5A5, SCx_ACK tied 1 -> SCx_REQ=1 with ADDR 0x10/WDT 0x0A5A5A5A5 in the next cycle, SxRDY=1, SxERR=0.
- **Wait-state read:** ADDR=0x20, read, ACK after 3 cycles, RDT=0x12345678 -> SxRDY=0 for 3 cycles, then 1 with SxRDT=0x12345678; SxRDT holds 0x12345678 afterward.
- **Misaligned access:** MxSZ=2, ADDR=0x22 -> no SCx_REQ; SxRDY/SxERR = 0/1 then 1/1; back to ST_IDLE.
- **Pipelined beats:** 4 back-to-back reads at 0x0/0x4/0x8/0xC with a zero-wait core -> 4 consecutive SxRDY=1 cycles, SCx_ADDR stepping by 4 each cycle.
- **Reset abort:** nRST asserted during a pending ST_DATA -> SCx_REQ=0 and SxRDY=1 asynchronously; the next transfer after release completes normally.
- **Timeout:** with SLV_WRP_TIMEOUT_EN, TO_CYCLES=8, core never ACKs -> two-cycle error response after 8 data-phase cycles; SCx_REQ deasserted.
